// File: rtl/bram_stream_reader_if.sv
// AXI-Stream bundle carrying RAM words out of the reader.
//   tdata  : stream payload, DATA_WIDTH bits
//   tvalid : payload valid
//   tready : downstream ready
//   tlast  : final beat of a transfer
interface bram_stream_reader_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bram_stream_reader.sv
// Sequential read engine for RAM port B. On start it walks base_addr ..
// base_addr+length-1, absorbs the one-cycle read latency and streams the words
// in address order through a 2-entry output buffer.
//   aclk, aresetn : clock, asynchronous active-low reset
//   start         : command strobe, honoured only when idle
//   base_addr     : first word address, sampled with start
//   length        : word count, sampled with start (0 = no reads, just done)
//   busy          : transfer in progress
//   done          : one-cycle completion pulse
//   bram_addr     : registered read address to RAM port B
//   bram_rdata    : RAM data for the address presented last cycle
//   m_axis        : AXI-Stream master (tdata/tvalid/tready/tlast)
module bram_stream_reader #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_rdata,
   bram_stream_reader_if.master  m_axis
);

   localparam int unsigned LVL_W = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                state;
   state_t                state_next;

   logic [LEN_WIDTH-1:0]  remaining;
   logic                  inflight;
   logic                  inflight_last;

   // Head entry drives the stream directly; skid entry holds the second word.
   logic                  head_vld;
   logic                  head_last;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  skid_vld;
   logic                  skid_last;
   logic [DATA_WIDTH-1:0] skid_data;

   logic                  pop;
   logic                  push;
   logic                  load;
   logic                  issue;
   logic                  last_issue;
   logic                  done_next;
   logic [LVL_W-1:0]      level;

   assign m_axis.tdata  = head_data;
   assign m_axis.tvalid = head_vld;
   assign m_axis.tlast  = head_last;

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, read issue and completion decode.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      issue      = 1'b0;
      last_issue = 1'b0;
      done_next  = 1'b0;
      pop        = head_vld & m_axis.tready;
      push       = inflight;
      // Words held or owed to the buffer; an issue is allowed only if the
      // buffer can still take this word after this cycle's pop.
      level      = LVL_W'(head_vld) + LVL_W'(skid_vld) + LVL_W'(inflight);

      case (state)
         S_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  // The first address goes out on the accepting edge.
                  load       = 1'b1;
                  last_issue = (length == LEN_WIDTH'(1));
                  state_next = last_issue ? S_DRAIN : S_RUN;
               end else begin
                  done_next = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (level < (LVL_W'(2) + LVL_W'(pop))) begin
               issue      = 1'b1;
               last_issue = (remaining == LEN_WIDTH'(1));
               if (last_issue) begin
                  state_next = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && head_last) begin
               state_next = S_IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Address counter, remaining count and status flags.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bram_addr     <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         inflight      <= load | issue;
         inflight_last <= last_issue;
         busy          <= (state_next != S_IDLE);
         done          <= done_next;
         if (load) begin
            bram_addr <= base_addr;
            remaining <= length - LEN_WIDTH'(1);
         end else if (issue) begin
            bram_addr <= bram_addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
         end
      end
   end

   // Two-entry output buffer; pushes land in the head when it is free or
   // being drained, otherwise in the skid entry.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         head_vld  <= 1'b0;
         head_last <= 1'b0;
         head_data <= '0;
         skid_vld  <= 1'b0;
         skid_last <= 1'b0;
         skid_data <= '0;
      end else if (pop) begin
         if (skid_vld) begin
            head_data <= skid_data;
            head_last <= skid_last;
            if (push) begin
               skid_data <= bram_rdata;
               skid_last <= inflight_last;
            end else begin
               skid_vld <= 1'b0;
            end
         end else if (push) begin
            head_data <= bram_rdata;
            head_last <= inflight_last;
         end else begin
            head_vld  <= 1'b0;
            head_last <= 1'b0;
         end
      end else if (push) begin
         if (!head_vld) begin
            head_vld  <= 1'b1;
            head_data <= bram_rdata;
            head_last <= inflight_last;
         end else begin
            skid_vld  <= 1'b1;
            skid_data <= bram_rdata;
            skid_last <= inflight_last;
         end
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised scoreboard bench for bram_stream_reader: the driver pushes the
// expected word sequence for every accepted command, an independent negedge
// monitor pops and compares each stream handshake.
module tb_bram_stream_reader;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 16;
   localparam int unsigned LW = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] length = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_rdata;

   bram_stream_reader_if #(.DATA_WIDTH(DW)) axis ();

   bram_stream_reader #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .LEN_WIDTH (LW)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .bram_addr (bram_addr),
      .bram_rdata(bram_rdata),
      .m_axis    (axis.master)
   );

   always #5 aclk = ~aclk;

   // RAM port B: data for the address registered on the previous edge.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign bram_rdata = mem[bram_addr];

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   exp_t          sb_q[$];
   int            done_q[$];
   int            beat_cyc[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            last_done = -1;
   int            issued_total = 0;
   int            beats_total = 0;
   bit            exp_busy = 1'b0;
   logic [AW-1:0] addr_track = '0;
   int            ready_mode = 0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_d = '0;
   logic          prev_l = 1'b0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   // tready driver: 0 = always ready, 1 = 1,0,0,1,0,1 pattern, 2 = random.
   initial begin
      logic [5:0] pat;
      int         pidx;
      pat  = 6'b101001;
      pidx = 0;
      axis.tready = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         case (ready_mode)
            0:       axis.tready = 1'b1;
            1: begin
               axis.tready = pat[pidx];
               pidx = (pidx + 1) % 6;
            end
            default: axis.tready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Monitor / scoreboard checker.
   always @(negedge aclk) begin
      bit   exp_d;
      exp_t e;
      if (aresetn) begin
         exp_d = (done_q.size() != 0) && (done_q[0] == cyc);
         if (exp_d) begin
            void'(done_q.pop_front());
            exp_busy = 1'b0;
         end
         if (done || exp_d) check("done_pulse", 64'(done), 64'(exp_d));
         check("busy", 64'(busy), 64'(exp_busy));
         if (busy && bram_addr != addr_track) begin
            check("addr_step", 64'(bram_addr), 64'(AW'(addr_track + AW'(1))));
            addr_track = bram_addr;
            issued_total++;
         end
         if (busy) check("buffer_bound", 64'((issued_total - beats_total) <= 2), 64'(1));
         if (prev_stall) begin
            check("stall_valid", 64'(axis.tvalid), 64'(1));
            check("stall_data", 64'(axis.tdata), 64'(prev_d));
            check("stall_last", 64'(axis.tlast), 64'(prev_l));
         end
         if (axis.tvalid && axis.tready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_beat", 64'(axis.tvalid), 64'(0));
            end else begin
               e = sb_q.pop_front();
               check("beat_data", 64'(axis.tdata), 64'(e.d));
               check("beat_last", 64'(axis.tlast), 64'(e.l));
               if (e.l) begin
                  done_q.push_back(cyc + 1);
                  last_done = cyc + 1;
               end
            end
            beats_total++;
            beat_cyc.push_back(cyc);
         end
         prev_stall = axis.tvalid && !axis.tready;
         prev_d     = axis.tdata;
         prev_l     = axis.tlast;
      end
   end

   // Issue a command; must be called just after a rising edge.
   task automatic start_xfer(input logic [AW-1:0] base, input logic [LW-1:0] len, output int c);
      logic [AW-1:0] a;
      exp_t          e;
      c         = cyc;
      start     = 1'b1;
      base_addr = base;
      length    = len;
      for (int i = 0; i < int'(len); i++) begin
         a   = base + AW'(i);
         e.d = mem[a];
         e.l = (i == int'(len) - 1);
         sb_q.push_back(e);
      end
      if (len == '0) begin
         done_q.push_back(c + 1);
         last_done = c + 1;
      end
      @(posedge aclk);
      #1;
      start = 1'b0;
      if (len != '0) begin
         exp_busy   = 1'b1;
         addr_track = base;
         issued_total++;
         check("first_addr", 64'(bram_addr), 64'(base));
         check("first_valid_low", 64'(axis.tvalid), 64'(0));
      end
   endtask

   // Pulse start with a random command that must be ignored.
   task automatic ignored_start();
      start     = 1'b1;
      base_addr = AW'($urandom);
      length    = LW'($urandom_range(1, 50));
      @(posedge aclk);
      #1;
      start = 1'b0;
   endtask

   // Returns just after the edge that opens the done cycle.
   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || cyc < last_done) && n < budget) begin
         @(posedge aclk);
         #1;
         n++;
      end
      if (n >= budget) timeout_fail("wait_done");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_addr"}, 64'(bram_addr), 64'(0));
      check({tag, "_tvalid"}, 64'(axis.tvalid), 64'(0));
      check({tag, "_tlast"}, 64'(axis.tlast), 64'(0));
      check({tag, "_tdata"}, 64'(axis.tdata), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c;
      int c2;
      int bi;
      int b0;
      int n;
      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

      // Reset values.
      #1 aresetn = 1'b0;
      #2;
      check_reset_outputs("rst");
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      #1;

      // Full-rate transfer: 2-cycle latency, 4 back-to-back beats.
      ready_mode = 0;
      bi = beat_cyc.size();
      start_xfer(16'h0010, 16'd4, c);
      @(posedge aclk);
      #1;
      check("t1_valid_after_e1", 64'(axis.tvalid), 64'(1));
      wait_done(100);
      check("t1_first_beat_cyc", 64'(beat_cyc[bi]), 64'(c + 2));
      check("t1_last_beat_cyc", 64'(beat_cyc[bi + 3]), 64'(c + 5));
      check("t1_done_cyc", 64'(cyc), 64'(c + 6));
      @(posedge aclk);
      #1;

      // Same transfer under the stall pattern.
      ready_mode = 1;
      start_xfer(16'h0010, 16'd4, c);
      wait_done(200);
      @(posedge aclk);
      #1;

      // Single word, then zero length.
      ready_mode = 0;
      start_xfer(16'h0005, 16'd1, c);
      wait_done(100);
      @(posedge aclk);
      #1;
      start_xfer(16'h0123, 16'd0, c);
      wait_done(100);
      check("len0_done_cyc", 64'(cyc), 64'(c + 1));
      repeat (3) @(posedge aclk);
      #1;

      // Address wrap.
      ready_mode = 2;
      start_xfer(16'hFFFE, 16'd4, c);
      wait_done(200);
      check("wrap_final_addr", 64'(bram_addr), 64'(16'h0001));
      @(posedge aclk);
      #1;

      // Reset after two of eight beats.
      ready_mode = 1;
      b0 = beats_total;
      start_xfer(AW'($urandom), 16'd8, c);
      n = 0;
      while (beats_total - b0 < 2 && n < 100) begin
         @(posedge aclk);
         #1;
         n++;
      end
      if (n >= 100) timeout_fail("reset_wait_beats");
      #2 aresetn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      sb_q.delete();
      done_q.delete();
      exp_busy     = 1'b0;
      prev_stall   = 1'b0;
      issued_total = beats_total;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      ready_mode = 0;
      start_xfer(AW'($urandom), 16'd8, c);
      wait_done(100);
      @(posedge aclk);
      #1;

      // Start while busy is ignored; start in the done cycle is taken.
      ready_mode = 0;
      start_xfer(16'h0400, 16'd6, c);
      @(posedge aclk);
      #1;
      ignored_start();
      wait_done(100);
      bi = beat_cyc.size();
      start_xfer(16'h0800, 16'd5, c2);
      wait_done(100);
      check("b2b_first_beat_cyc", 64'(beat_cyc[bi]), 64'(c2 + 2));

      // Random transfers.
      for (int k = 0; k < 30; k++) begin
         ready_mode = $urandom_range(0, 2);
         start_xfer(AW'($urandom), LW'($urandom_range(0, 24)), c);
         wait_done(2000);
         if ($urandom_range(0, 1) != 0) begin
            repeat ($urandom_range(1, 3)) @(posedge aclk);
            #1;
         end
      end

      repeat (5) @(posedge aclk);
      #1;
      check("sb_empty", 64'(sb_q.size()), 64'(0));
      check("done_q_empty", 64'(done_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
